hazard_scoreboard: RTL

- Parametrised hazard detection and operand forwarding unit for the in-order pipeline, sitting in ID beside the register file.
- Keeps its own tag pipeline of in-flight destination writes, one entry per post-ID stage (EX..WB). Each entry records the stage at which its result becomes valid.
- Resolves rs1/rs2 operands with per-instruction result latency (ALU result in EX, load result late), an optional no-forwarding mode and a global hold.
- Replaces the fixed 4-stage forwarding/stall logic with one block that scales in stage count, register count and width.

---
 rtl/hazard_scoreboard_pkg.sv | 26 ++
 rtl/hazard_scoreboard_if.sv | 49 ++++
 rtl/hazard_scoreboard_operand_resolver.sv | 44 ++++
 rtl/hazard_scoreboard.sv | 94 +++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and helpers for the hazard scoreboard.
// Entry fields are sized for the largest supported configuration
// (up to 64 registers, up to 16 stages); narrower indices are zero-extended.
package hazard_pkg;

   localparam int SB_REG_W = 6;
   localparam int SB_STG_W = 4;

   // Stage index at which typical results become forwardable.
   localparam int READY_ALU  = 0;
   localparam int READY_LOAD = 2;

   typedef struct packed {
      logic                valid;
      logic [SB_REG_W-1:0] rd;
      logic [SB_STG_W-1:0] ready_stage;
   } sb_entry_t;

   // A result can never become ready later than the last tracked stage.
   function automatic logic [SB_STG_W-1:0] clamp_ready(input logic [SB_STG_W-1:0] ready,
                                                       input int num_stages);
      if (int'(ready) >= num_stages) return SB_STG_W'(num_stages - 1);
      return ready;
   endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Issue / operand bundle between the ID stage and the hazard scoreboard.
//
// Handshake: ID presents an instruction with issue_valid=1. stall acts as the
// inverse of ready: the instruction is accepted (and, if it writes a register,
// enters the tag pipeline) on a posedge where issue_valid=1, stall=0 and
// flush=0. While stall=1 ID must keep the same instruction and operands stable.
interface hazard_scoreboard_if #(
   parameter int NUM_STAGES = 4,
   parameter int NUM_REGS   = 16,
   parameter int DATA_W     = 32
);
   localparam int REG_W = $clog2(NUM_REGS);
   localparam int STG_W = $clog2(NUM_STAGES);

   logic                         issue_valid;
   logic                         issue_we;
   logic [REG_W-1:0]             issue_rd;
   logic [STG_W-1:0]             issue_ready_stage;
   logic [REG_W-1:0]             rs1;
   logic [REG_W-1:0]             rs2;
   logic                         rs1_used;
   logic                         rs2_used;
   logic [DATA_W-1:0]            regfile_rs1_data;
   logic [DATA_W-1:0]            regfile_rs2_data;
   logic [NUM_STAGES*DATA_W-1:0] stage_data;
   logic                         flush;
   logic                         hold;
   logic                         stall;
   logic [DATA_W-1:0]            rs1_data;
   logic [DATA_W-1:0]            rs2_data;
   logic                         rs1_fwd;
   logic                         rs2_fwd;
   logic [STG_W:0]               inflight_count;

   modport master (
      output issue_valid, issue_we, issue_rd, issue_ready_stage,
      output rs1, rs2, rs1_used, rs2_used,
      output regfile_rs1_data, regfile_rs2_data, stage_data, flush, hold,
      input  stall, rs1_data, rs2_data, rs1_fwd, rs2_fwd, inflight_count
   );

   modport slave (
      input  issue_valid, issue_we, issue_rd, issue_ready_stage,
      input  rs1, rs2, rs1_used, rs2_used,
      input  regfile_rs1_data, regfile_rs2_data, stage_data, flush, hold,
      output stall, rs1_data, rs2_data, rs1_fwd, rs2_fwd, inflight_count
   );

endinterface

// File: rtl/hazard_scoreboard_operand_resolver.sv
// Resolves one source operand against the tag pipeline: finds the youngest
// in-flight writer of rs and either forwards its stage result or flags a hazard.
module operand_resolver
   import hazard_pkg::*;
#(
   parameter int NUM_STAGES = 4,
   parameter int NUM_REGS   = 16,
   parameter int DATA_W     = 32,
   parameter int FORWARD_EN = 1
) (
   input  sb_entry_t [NUM_STAGES-1:0]    entries,
   input  logic [$clog2(NUM_REGS)-1:0]   rs,
   input  logic                          used,
   input  logic [DATA_W-1:0]             regfile_data,
   input  logic [NUM_STAGES*DATA_W-1:0]  stage_data,
   output logic [DATA_W-1:0]             data,
   output logic                          fwd,
   output logic                          hazard
);

   logic found;

   // Priority scan from EX outward; the first match is the youngest writer.
   always_comb begin
      data   = regfile_data;
      fwd    = 1'b0;
      hazard = 1'b0;
      found  = 1'b0;
      if (used && (rs != '0)) begin
         for (int i = 0; i < NUM_STAGES; i++) begin
            if (!found && entries[i].valid && (entries[i].rd == SB_REG_W'(rs))) begin
               found = 1'b1;
               if ((FORWARD_EN != 0) && (SB_STG_W'(i) >= entries[i].ready_stage)) begin
                  data = stage_data[i*DATA_W +: DATA_W];
                  fwd  = 1'b1;
               end else begin
                  hazard = 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard detection and operand forwarding for the in-order pipeline.
// Tracks one destination tag per post-ID stage and resolves rs1/rs2.
// The bus interface must be instantiated with the same parameter values.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int NUM_STAGES = 4,
   parameter int NUM_REGS   = 16,
   parameter int DATA_W     = 32,
   parameter int FORWARD_EN = 1
) (
   input  logic          clk,
   input  logic          rst,
   hazard_scoreboard_if.slave bus
);

   localparam int STG_W = $clog2(NUM_STAGES);

   sb_entry_t [NUM_STAGES-1:0] entries;
   sb_entry_t                  new_entry;
   logic                       hazard1;
   logic                       hazard2;
   logic                       stall_c;
   logic [STG_W:0]             count;

   // Flush discards the ID instruction, so its hazards must not stall.
   always_comb begin
      stall_c = bus.hold | ((hazard1 | hazard2) & bus.issue_valid & ~bus.flush);
   end

   // Tag for the instruction leaving ID; a stalled or flushed one becomes a bubble.
   always_comb begin
      new_entry.valid       = bus.issue_valid & bus.issue_we & (bus.issue_rd != '0)
                              & ~stall_c & ~bus.flush;
      new_entry.rd          = SB_REG_W'(bus.issue_rd);
      new_entry.ready_stage = clamp_ready(SB_STG_W'(bus.issue_ready_stage), NUM_STAGES);
   end

   // Tag pipeline: shifts one stage per cycle unless held; the WB entry drops off.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         entries <= '0;
      end else if (!bus.hold) begin
         entries[0] <= new_entry;
         for (int i = 1; i < NUM_STAGES; i++) begin
            entries[i] <= entries[i-1];
         end
      end
   end

   // Population count of valid entries.
   always_comb begin
      count = '0;
      for (int i = 0; i < NUM_STAGES; i++) begin
         count = count + (STG_W+1)'(entries[i].valid);
      end
   end

   operand_resolver #(
      .NUM_STAGES (NUM_STAGES),
      .NUM_REGS   (NUM_REGS),
      .DATA_W     (DATA_W),
      .FORWARD_EN (FORWARD_EN)
   ) u_rs1 (
      .entries      (entries),
      .rs           (bus.rs1),
      .used         (bus.rs1_used),
      .regfile_data (bus.regfile_rs1_data),
      .stage_data   (bus.stage_data),
      .data         (bus.rs1_data),
      .fwd          (bus.rs1_fwd),
      .hazard       (hazard1)
   );

   operand_resolver #(
      .NUM_STAGES (NUM_STAGES),
      .NUM_REGS   (NUM_REGS),
      .DATA_W     (DATA_W),
      .FORWARD_EN (FORWARD_EN)
   ) u_rs2 (
      .entries      (entries),
      .rs           (bus.rs2),
      .used         (bus.rs2_used),
      .regfile_data (bus.regfile_rs2_data),
      .stage_data   (bus.stage_data),
      .data         (bus.rs2_data),
      .fwd          (bus.rs2_fwd),
      .hazard       (hazard2)
   );

   assign bus.stall          = stall_c;
   assign bus.inflight_count = count;

endmodule
